// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions: default field widths, opcode map and opcode classes
// used by the decode stage and anything else that needs to interpret opcodes.
package gpu_isa_pkg;

  localparam int OPC_W  = 4;
  localparam int REG_W  = 4;
  localparam int DATA_W = 16;

  // Opcodes are held at a fixed generous width so the map is independent of OPC_W.
  localparam int OPC_MAX_W = 16;

  localparam logic [OPC_MAX_W-1:0] OP_NOP  = 16'h0;
  localparam logic [OPC_MAX_W-1:0] OP_ADD  = 16'h1;
  localparam logic [OPC_MAX_W-1:0] OP_SUB  = 16'h2;
  localparam logic [OPC_MAX_W-1:0] OP_MUL  = 16'h3;
  localparam logic [OPC_MAX_W-1:0] OP_AND  = 16'h4;
  localparam logic [OPC_MAX_W-1:0] OP_OR   = 16'h5;
  localparam logic [OPC_MAX_W-1:0] OP_XOR  = 16'h6;
  localparam logic [OPC_MAX_W-1:0] OP_LDI  = 16'h7;
  localparam logic [OPC_MAX_W-1:0] OP_ADDI = 16'h8;
  localparam logic [OPC_MAX_W-1:0] OP_LD   = 16'h9;
  localparam logic [OPC_MAX_W-1:0] OP_ST   = 16'hA;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_REG,
    CLS_IMM_ZX,
    CLS_IMM_SX,
    CLS_STORE,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify_op(input logic [OPC_MAX_W-1:0] op);
    op_class_e cls;
    case (op)
      OP_NOP:                                       cls = CLS_NOP;
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: cls = CLS_REG;
      OP_LDI, OP_LD:                                cls = CLS_IMM_ZX;
      OP_ADDI:                                      cls = CLS_IMM_SX;
      OP_ST:                                        cls = CLS_STORE;
      default:                                      cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction slicer: positional field extraction, opcode
// classification and immediate extension. Zero latency, no flow control.
module instr_field_decode #(
  parameter int OPC_W   = gpu_isa_pkg::OPC_W,
  parameter int REG_W   = gpu_isa_pkg::REG_W,
  parameter int INSTR_W = OPC_W + 3*REG_W,
  parameter int IMM_W   = 2*REG_W,
  parameter int DATA_W  = gpu_isa_pkg::DATA_W
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   dest,
  output logic [REG_W-1:0]   src1,
  output logic [REG_W-1:0]   src2,
  output logic [DATA_W-1:0]  imm,
  output logic               is_imm,
  output logic               wr_en,
  output logic               illegal
);
  import gpu_isa_pkg::*;

  op_class_e        cls;
  logic [IMM_W-1:0] imm_raw;

  assign opcode  = instr[INSTR_W-1 -: OPC_W];
  assign dest    = instr[INSTR_W-OPC_W-1 -: REG_W];
  assign src1    = instr[2*REG_W-1 -: REG_W];
  assign src2    = instr[REG_W-1:0];
  assign imm_raw = instr[IMM_W-1:0];
  assign cls     = classify_op(OPC_MAX_W'(opcode));

  always_comb begin
    is_imm  = 1'b0;
    wr_en   = 1'b0;
    illegal = 1'b0;
    imm     = DATA_W'(imm_raw);
    case (cls)
      CLS_REG:    wr_en = 1'b1;
      CLS_IMM_ZX: begin is_imm = 1'b1; wr_en = 1'b1; end
      CLS_IMM_SX: begin
        is_imm = 1'b1;
        wr_en  = 1'b1;
        imm    = DATA_W'($signed(imm_raw));
      end
      CLS_STORE:  is_imm = 1'b1;
      CLS_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with 2-entry skid buffer: 1-cycle latency, full throughput.
// in_ready is registered (!skid_valid); outputs hold while out_valid && !out_ready.
module instr_decode_stage #(
  parameter int OPC_W   = gpu_isa_pkg::OPC_W,
  parameter int REG_W   = gpu_isa_pkg::REG_W,
  parameter int INSTR_W = OPC_W + 3*REG_W,
  parameter int IMM_W   = 2*REG_W,
  parameter int DATA_W  = gpu_isa_pkg::DATA_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_W-1:0]   out_dest,
  output logic [REG_W-1:0]   out_src1,
  output logic [REG_W-1:0]   out_src2,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_is_imm,
  output logic               out_wr_en,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);
  import gpu_isa_pkg::*;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [DATA_W-1:0] imm;
    logic              is_imm;
    logic              wr_en;
    logic              illegal;
  } dec_t;

  dec_t dec, main_q, skid_q;
  logic main_valid, skid_valid;
  logic accept, xfer;

  instr_field_decode #(
    .OPC_W(OPC_W), .REG_W(REG_W), .INSTR_W(INSTR_W), .IMM_W(IMM_W), .DATA_W(DATA_W)
  ) u_field_decode (
    .instr   (in_instr),
    .opcode  (dec.opcode),
    .dest    (dec.dest),
    .src1    (dec.src1),
    .src2    (dec.src2),
    .imm     (dec.imm),
    .is_imm  (dec.is_imm),
    .wr_en   (dec.wr_en),
    .illegal (dec.illegal)
  );

  assign accept = in_valid && in_ready;
  assign xfer   = main_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready    <= 1'b1;
      illegal_cnt <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      if (xfer) begin
        // Retiring main is refilled from skid first so ordering is preserved.
        if (skid_valid) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end else if (accept) begin
          main_q <= dec;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (main_valid) begin
          skid_q     <= dec;
          skid_valid <= 1'b1;
          in_ready   <= 1'b0;
        end else begin
          main_q     <= dec;
          main_valid <= 1'b1;
        end
      end
      if (xfer && main_q.illegal && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_opcode  = main_q.opcode;
  assign out_dest    = main_q.dest;
  assign out_src1    = main_q.src1;
  assign out_src2    = main_q.src2;
  assign out_imm     = main_q.imm;
  assign out_is_imm  = main_q.is_imm;
  assign out_wr_en   = main_q.wr_en;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; a second instance with CNT_W=2 shares
// the stimulus to exercise counter saturation.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_instr;

  logic        in_ready, out_valid, out_is_imm, out_wr_en, out_illegal;
  logic [3:0]  out_opcode, out_dest, out_src1, out_src2;
  logic [15:0] out_imm, illegal_cnt;

  logic        s_in_ready, s_out_valid, s_out_is_imm, s_out_wr_en, s_out_illegal;
  logic [3:0]  s_out_opcode, s_out_dest, s_out_src1, s_out_src2;
  logic [15:0] s_out_imm;
  logic [1:0]  s_illegal_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_dest(out_dest), .out_src1(out_src1), .out_src2(out_src2),
    .out_imm(out_imm), .out_is_imm(out_is_imm), .out_wr_en(out_wr_en),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  instr_decode_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_opcode(s_out_opcode), .out_dest(s_out_dest), .out_src1(s_out_src1), .out_src2(s_out_src2),
    .out_imm(s_out_imm), .out_is_imm(s_out_is_imm), .out_wr_en(s_out_wr_en),
    .out_illegal(s_out_illegal), .illegal_cnt(s_illegal_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 16'h0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    checks++; if ({out_opcode, out_dest, out_src1, out_src2, out_imm, out_is_imm, out_wr_en, out_illegal} !== 35'h0) begin
      errors++; $display("FAIL reset_fields: got op=%h imm=%h want all zero", out_opcode, out_imm); end
    checks++; if (illegal_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", illegal_cnt); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h1234;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    checks++; if ({out_opcode, out_dest, out_src1, out_src2} !== 16'h1234) begin
      errors++; $display("FAIL basic_fields: got %h%h%h%h want 1234", out_opcode, out_dest, out_src1, out_src2); end
    checks++; if ({out_is_imm, out_wr_en, out_illegal} !== 3'b010) begin
      errors++; $display("FAIL basic_flags: got %b want 010", {out_is_imm, out_wr_en, out_illegal}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_imm();
    logic [15:0] instr_v [4] = '{16'h85F0, 16'h7180, 16'hA123, 16'h0000};
    logic [15:0] imm_v   [4] = '{16'hFFF0, 16'h0080, 16'h0023, 16'h0000};
    logic [1:0]  flg_v   [4] = '{2'b11,    2'b11,    2'b10,    2'b00};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = instr_v[i];
      tick();
      in_valid = 1'b0;
      checks++; if (out_imm !== imm_v[i]) begin
        errors++; $display("FAIL imm_ext[%0d]: got %h want %h", i, out_imm, imm_v[i]); end
      checks++; if ({out_is_imm, out_wr_en} !== flg_v[i]) begin
        errors++; $display("FAIL imm_flags[%0d]: got %b want %b", i, {out_is_imm, out_wr_en}, flg_v[i]); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h1111;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %0b want 1", in_ready); end
    in_instr = 16'h2222;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2: got %0b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || {out_opcode, out_dest, out_src1, out_src2} !== 16'h1111) begin
      errors++; $display("FAIL bp_hold: got v=%0b %h%h%h%h want v=1 1111", out_valid, out_opcode, out_dest, out_src1, out_src2); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || {out_opcode, out_dest, out_src1, out_src2} !== 16'h2222) begin
      errors++; $display("FAIL bp_second: got v=%0b %h%h%h%h want v=1 2222", out_valid, out_opcode, out_dest, out_src1, out_src2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready3: got %0b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 16'hF000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({out_valid, out_illegal, out_wr_en, out_is_imm} !== 4'b1100) begin
        errors++; $display("FAIL illegal_flags[%0d]: got %b want 1100", i, {out_valid, out_illegal, out_wr_en, out_is_imm}); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (illegal_cnt !== 16'd3) begin errors++; $display("FAIL illegal_cnt3: got %0d want 3", illegal_cnt); end
    checks++; if (s_illegal_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt3: got %0d want 3", s_illegal_cnt); end
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (illegal_cnt !== 16'd5) begin errors++; $display("FAIL illegal_cnt5: got %0d want 5", illegal_cnt); end
    checks++; if (s_illegal_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d want 3", s_illegal_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h1111;
    tick();
    in_instr = 16'h2222;
    tick();
    flush = 1'b1; in_instr = 16'h3333;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_full: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_replay: got %0b want 0", out_valid); end
    // Illegal result retiring on the flush edge must not be counted.
    in_valid = 1'b1; in_instr = 16'hF000;
    tick();
    flush = 1'b1; in_instr = 16'h4444;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_accept: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got %0b want 0", out_valid); end
    checks++; if (illegal_cnt !== 16'd5) begin errors++; $display("FAIL flush_cnt: got %0d want 5", illegal_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] instr_w;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr_w  = 16'h4000 | 16'(i);
      in_valid = 1'b1; in_instr = instr_w;
      tick();
      checks++; if (out_valid !== 1'b1 || out_src2 !== 4'(i)) begin
        errors++; $display("FAIL stream[%0d]: got v=%0b src2=%h want v=1 src2=%h", i, out_valid, out_src2, 4'(i)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 16'h5000 | 16'(i);
      tick();
    end
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL midrst_state: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready); end
    checks++; if (illegal_cnt !== 16'd0 || s_illegal_cnt !== 2'd0) begin
      errors++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", illegal_cnt, s_illegal_cnt); end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after: got %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm();
    test_backpressure();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
